// File: rtl/pll_cal_ctrl.sv
// pll_cal_ctrl: SAR calibration and lock monitor for a PLL delay-line VCO.
//   clk/rst_n      reference clock, async active-low reset
//   ena            block enable; 0 holds the block in IDLE at reset values
//   start          calibration request pulse (honoured in IDLE and FAIL)
//   target         expected feedback edges per measurement window
//   fb_in          divided VCO feedback, asynchronous to clk
//   delay_code     VCO delay-line code
//   loop_en        enables the analog loop (SETTLE, MONITOR)
//   busy           calibrating, or monitoring before the first lock
//   locked         LOCK_WINDOWS consecutive in-tolerance windows seen
//   cal_fail       calibration ended at a code rail far from target
//   fb_count       edge count of the last completed window
module pll_cal_ctrl #(
  parameter int CODE_W       = 5,
  parameter int WIN_LOG2     = 6,
  parameter int LOCK_TOL     = 2,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [7:0]        target,
  input  logic              fb_in,
  output logic [CODE_W-1:0] delay_code,
  output logic              loop_en,
  output logic              busy,
  output logic              locked,
  output logic              cal_fail,
  output logic [7:0]        fb_count
);
  typedef enum logic [2:0] {IDLE, CAL_MEAS, CAL_STEP, SETTLE, MONITOR, FAIL} state_t;
  localparam int BW = CODE_W > 1 ? $clog2(CODE_W) : 1;
  localparam int RW = $clog2(LOCK_WINDOWS + 1);
  localparam logic [CODE_W-1:0] MID = CODE_W'(1) << (CODE_W - 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(LOCK_WINDOWS);
  state_t st_q, st_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WIN_LOG2-1:0] win_q, win_d;
  logic [7:0] cnt_q, cnt_d, fbc_q, fbc_d, cnt_n;
  logic [RW-1:0] run_q, run_d;
  logic lock_q, lock_d, lk1_q, lk1_d;
  logic [2:0] sync_q;
  logic edge_w, meas, last, restart, in_tol, mild;
  logic signed [8:0] err;
  logic [8:0] aerr;
  // sync_q[0..1] synchronize fb_in, sync_q[2] is the delay FF for edge detection
  assign edge_w = sync_q[1] & ~sync_q[2];
  assign meas = st_q inside {CAL_MEAS, SETTLE, MONITOR};
  assign last = meas && (win_q == '1);
  assign cnt_n = (cnt_q == 8'hFF) ? cnt_q : cnt_q + {7'd0, edge_w};
  // decisions use the count including the window's final cycle, so windows run back to back
  assign err = $signed({1'b0, cnt_n}) - $signed({1'b0, target});
  assign aerr = err[8] ? 9'(-err) : 9'(err);
  assign in_tol = aerr <= 9'(LOCK_TOL);
  assign mild = aerr <= 9'(4 * LOCK_TOL);
  always_comb begin
    st_d = st_q;
    code_d = code_q;
    bit_d = bit_q;
    win_d = meas ? win_q + 1'b1 : '0;
    cnt_d = (meas && !last) ? cnt_n : '0;
    fbc_d = last ? cnt_n : fbc_q;
    run_d = run_q;
    lock_d = lock_q;
    lk1_d = lk1_q;
    restart = 1'b0;
    if (!ena) begin
      st_d = IDLE;
      code_d = MID;
      bit_d = '0;
      win_d = '0;
      cnt_d = '0;
      fbc_d = '0;
      run_d = '0;
      lock_d = 1'b0;
      lk1_d = 1'b0;
    end else begin
      case (st_q)
        IDLE:     restart = start;
        CAL_MEAS: st_d = last ? CAL_STEP : CAL_MEAS;
        CAL_STEP: begin
          code_d[bit_q] = fbc_q >= target;
          if (bit_q != '0) begin
            code_d[bit_q - 1'b1] = 1'b1;
            bit_d = bit_q - 1'b1;
            st_d = CAL_MEAS;
          end else st_d = SETTLE;
        end
        SETTLE:   if (last) st_d = ((code_q == '0 || code_q == '1) && !mild) ? FAIL : MONITOR;
        MONITOR:  if (last) begin
          if (in_tol) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
            lock_d = run_d == RUN_MAX;
            lk1_d = lk1_q | lock_d;
          end else if (mild) begin
            run_d = '0;
            lock_d = 1'b0;
          end else restart = 1'b1;
        end
        FAIL:     restart = start;
        default:  st_d = IDLE;
      endcase
      if (restart) begin
        st_d = CAL_MEAS;
        code_d = MID;
        bit_d = BW'(CODE_W - 1);
        win_d = '0;
        cnt_d = '0;
        run_d = '0;
        lock_d = 1'b0;
        lk1_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
      code_q <= MID;
      bit_q <= '0;
      win_q <= '0;
      cnt_q <= '0;
      fbc_q <= '0;
      run_q <= '0;
      lock_q <= 1'b0;
      lk1_q <= 1'b0;
      sync_q <= '0;
    end else begin
      st_q <= st_d;
      code_q <= code_d;
      bit_q <= bit_d;
      win_q <= win_d;
      cnt_q <= cnt_d;
      fbc_q <= fbc_d;
      run_q <= run_d;
      lock_q <= lock_d;
      lk1_q <= lk1_d;
      sync_q <= {sync_q[1:0], fb_in};
    end
  end
  assign delay_code = code_q;
  assign loop_en = st_q inside {SETTLE, MONITOR};
  // busy drops at the first lock of a monitoring session and stays low through mild errors
  assign busy = (st_q inside {CAL_MEAS, CAL_STEP, SETTLE}) || (st_q == MONITOR && !lk1_q);
  assign locked = lock_q;
  assign cal_fail = st_q == FAIL;
  assign fb_count = fbc_q;
endmodule

// File: tb/tb_pll_cal_ctrl.sv
// tb_pll_cal_ctrl: scoreboard bench; each output change is checked against the next expected record
module tb_pll_cal_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, start = 1'b0, fb_in = 1'b0;
  logic [7:0] target = 8'd0;
  logic [4:0] delay_code;
  logic loop_en, busy, locked, cal_fail;
  logic [7:0] fb_count;
  pll_cal_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .target(target), .fb_in(fb_in),
    .delay_code(delay_code), .loop_en(loop_en), .busy(busy), .locked(locked),
    .cal_fail(cal_fail), .fb_count(fb_count)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    int         cyc;
    logic [8:0] v;
    logic [7:0] fbc;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  int t0, t1, t2, t3;
  task automatic expect_at(input int c, input int code, input bit le, input bit bz, input bit lk, input bit cf, input int fbc);
    exp_t e;
    e.cyc = c;
    e.v = {5'(code), le, bz, lk, cf};
    e.fbc = 8'(fbc);
    q.push_back(e);
  endtask
  logic [8:0] prev, v;
  bit first = 1'b1;
  exp_t m;
  always @(negedge clk) begin
    v = {delay_code, loop_en, busy, locked, cal_fail};
    if (first || v !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got code=%0d le/bz/lk/cf=%b fbc=%0d, required no change", cyc, v[8:4], v[3:0], fb_count);
      end else begin
        m = q.pop_front();
        if (cyc != m.cyc || v !== m.v || fb_count !== m.fbc) begin
          errors++;
          $display("FAIL out_change got cyc=%0d code=%0d le/bz/lk/cf=%b fbc=%0d, required cyc=%0d code=%0d le/bz/lk/cf=%b fbc=%0d",
                   cyc, v[8:4], v[3:0], fb_count, m.cyc, m.v[8:4], m.v[3:0], m.fbc);
        end
      end
      prev = v;
      first = 1'b0;
    end
  end
  task automatic tick(input bit st, input bit fb);
    @(posedge clk);
    #1 start = st;
    fb_in = fb;
  endtask
  // one 64-cycle window of plant feedback: n pulses on odd offsets; n<0 models count = 35 - delay_code
  task automatic win(input int n, input int sp);
    int nn;
    nn = n;
    for (int c = 0; c < 64; c++) begin
      @(posedge clk);
      #1;
      if (c == 0 && n < 0) nn = 35 - int'(delay_code);
      start = (c == sp);
      fb_in = (c % 2 == 1) && (c < 2 * nn);
    end
  endtask
  initial begin
    expect_at(1, 16, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ena = 1'b1;
    target = 8'd20;
    repeat (3) tick(0, 0);
    // SAR calibration, lock, mild error, gross error and recalibration
    @(posedge clk);
    #1 start = 1'b1;
    t0 = cyc;
    expect_at(t0 + 1, 16, 0, 1, 0, 0, 0);
    expect_at(t0 + 66, 8, 0, 1, 0, 0, 19);
    expect_at(t0 + 131, 12, 0, 1, 0, 0, 27);
    expect_at(t0 + 196, 14, 0, 1, 0, 0, 23);
    expect_at(t0 + 261, 15, 0, 1, 0, 0, 21);
    expect_at(t0 + 326, 15, 1, 1, 0, 0, 20);
    expect_at(t0 + 646, 15, 1, 0, 1, 0, 20);
    expect_at(t0 + 710, 15, 1, 0, 0, 0, 23);
    expect_at(t0 + 966, 15, 1, 0, 1, 0, 20);
    expect_at(t0 + 1030, 16, 0, 1, 0, 0, 30);
    expect_at(t0 + 1095, 8, 0, 1, 0, 0, 19);
    expect_at(t0 + 1160, 16, 0, 0, 0, 0, 0);
    repeat (5) begin
      win(-1, -1);
      tick(0, 0);
    end
    repeat (5) win(-1, -1);
    win(23, -1);
    repeat (4) win(-1, -1);
    win(30, -1);
    win(-1, 10);
    tick(0, 0);
    win(-1, -1);
    @(posedge clk);
    #1 ena = 1'b0;
    fb_in = 1'b0;
    @(posedge clk);
    #1 ena = 1'b1;
    repeat (3) tick(0, 0);
    // feedback dead: SAR walks to code 0 and fails; start restarts, ena=0 aborts
    target = 8'd50;
    @(posedge clk);
    #1 start = 1'b1;
    t1 = cyc;
    expect_at(t1 + 1, 16, 0, 1, 0, 0, 0);
    expect_at(t1 + 66, 8, 0, 1, 0, 0, 0);
    expect_at(t1 + 131, 4, 0, 1, 0, 0, 0);
    expect_at(t1 + 196, 2, 0, 1, 0, 0, 0);
    expect_at(t1 + 261, 1, 0, 1, 0, 0, 0);
    expect_at(t1 + 326, 0, 1, 1, 0, 0, 0);
    expect_at(t1 + 390, 0, 0, 0, 0, 1, 0);
    repeat (400) tick(0, 0);
    @(posedge clk);
    #1 start = 1'b1;
    t2 = cyc;
    expect_at(t2 + 1, 16, 0, 1, 0, 0, 0);
    expect_at(t2 + 2, 16, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 start = 1'b0;
    ena = 1'b0;
    @(posedge clk);
    #1 ena = 1'b1;
    // fb_in toggling every cycle gives 32 edges in any window
    target = 8'd32;
    repeat (2) tick(0, 0);
    @(posedge clk);
    #1 start = 1'b1;
    fb_in = ~fb_in;
    t3 = cyc;
    expect_at(t3 + 1, 16, 0, 1, 0, 0, 0);
    expect_at(t3 + 66, 24, 0, 1, 0, 0, 32);
    expect_at(t3 + 131, 28, 0, 1, 0, 0, 32);
    expect_at(t3 + 196, 30, 0, 1, 0, 0, 32);
    expect_at(t3 + 261, 31, 0, 1, 0, 0, 32);
    expect_at(t3 + 326, 31, 1, 1, 0, 0, 32);
    expect_at(t3 + 646, 31, 1, 0, 1, 0, 32);
    repeat (700) begin
      @(posedge clk);
      #1 start = 1'b0;
      fb_in = ~fb_in;
    end
    // asynchronous reset mid-window must clear outputs within the same cycle
    @(posedge clk);
    #1 expect_at(cyc, 16, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) tick(0, 0);
    while (q.size() > 0) begin
      m = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_change got none, required cyc=%0d code=%0d le/bz/lk/cf=%b fbc=%0d", m.cyc, m.v[8:4], m.v[3:0], m.fbc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
